pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit; next generation of the 32-bit ripple adder.
//  Splits a WIDTH-bit operation into STAGES slices. Each pipeline stage adds one slice and
//  registers its carry forward. Uses a valid/ready handshake on both sides.
//  Sits between the operand-select logic and the ALU result mux. Throughput is one op/cycle.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline depth = number of slices; 1..WIDTH; slice width SW = WIDTH/STAGES
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      unit accepts beat this cycle
//  in1        in   WIDTH  operand A
//  in2        in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: A+B+cin ; 1: A-B-cin
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out (sub: 1 = no borrow)
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Arithmetic: B' = sub ? ~in2 : in2; c0 = sub ? ~cin : cin; {cout,sum} = in1 + B' + c0 (WIDTH+1 bits).
//    ovf = (in1[MSB] == B'[MSB]) && (sum[MSB] != in1[MSB]), computed on the unsaturated sum.
//  - Stage k (0..STAGES-1) adds slice k = bits [k*SW +: SW] plus the carry from stage k-1.
//    It carries the not-yet-added upper slices of in1/B' and the finished lower sum slices.
//  - Latency: a beat accepted at edge N appears on out_valid after edge N+STAGES-1.
//    STAGES=1 gives 1 register stage.
//  - Per-stage valid bit v[k]. Stage k advances when v[k] && (k==last ? out_ready : !v[k+1] || adv[k+1]).
//  - in_ready = !v[0] || adv[0]; purely combinational from out_ready and the valid bits.
//    There is no input-to-output combinational data path.
//  - Back-pressure: with out_ready=0 the pipe fills. in_ready drops once all STAGES slots hold data.
//    No beat is dropped or duplicated. Bubbles collapse.
//  - Output held stable (sum/cout/ovf) while out_valid && !out_ready.
//  - Simultaneous accept at input and output when full: allowed, throughput remains 1/cycle.
//  - Reset (synchronous, any cycle, incl. mid-operation): all v[k]<=0, all data regs <=0.
//    After reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 in the cycle after reset deasserts.
//    In-flight beats are discarded.
//  - in1/in2/cin/sub are sampled only on an accepted beat (in_valid && in_ready).
// CONFIGURATION
//  ADDER_SAT_EN defined: on ovf, sum is clamped. Positive overflow (in1[MSB]==0) gives 0111..1.
//    Negative overflow gives 1000..0. ovf is still asserted, cout is unchanged. Clamp applies in the last stage.
//    Latency is unchanged.
//  ADDER_SAT_EN undefined: sum wraps modulo 2^WIDTH. No clamp logic is present.
// TESTING
//  1. WIDTH=32,STAGES=4: in1=FFFF_FFFF,in2=0,cin=1,sub=0 -> 4 cycles later sum=0,cout=1,ovf=0
//     (carry ripples through all stages).
//  2. in1=7FFF_FFFF,in2=1,cin=0,sub=0 -> ovf=1, cout=0.
//     Without ADDER_SAT_EN: sum=8000_0000. With ADDER_SAT_EN: sum=7FFF_FFFF.
//  3. sub=1: in1=5,in2=7,cin=0 -> sum=FFFF_FFFE, cout=0 (borrow), ovf=0.
//     in1=8000_0000,in2=1 -> ovf=1.
//  4. Stream 16 back-to-back beats (in1=i,in2=i) while out_ready toggles 1,0,0,1...
//     -> results 2*i in order, none lost or duplicated; in_ready=0 only when 4 beats are held.
//  5. Assert rst for 1 cycle while 3 beats are in flight -> next cycle out_valid=0, sum=0, in_ready=1.
//     The first post-reset beat exits after exactly STAGES cycles.
//  6. Sweep STAGES in {1,2,8,32} at WIDTH=32, and WIDTH=8 with STAGES=2, using random operands
//     -> every result matches the reference model {cout,sum}=in1+B'+c0.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit operation split into STAGES carry-linked slices with valid/ready flow control.
// Optional feature: define ADDER_SAT_EN to clamp the result on signed overflow.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;
  localparam int unsigned MSB  = WIDTH - 1;

  logic [WIDTH-1:0]  b_in;
  logic              c0;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              ovf_q;

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] c_nx;
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [WIDTH-1:0]  s_nx  [STAGES];

  logic              ovf_nx;
  logic [WIDTH-1:0]  sum_nx;

  assign b_in = sub ? ~in2 : in2;
  assign c0   = sub ? ~cin : cin;

  // A stage moves when any slot downstream of it is free or the consumer takes the head.
  always_comb begin
    logic free;
    free = out_ready;
    adv  = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv[k] = v_q[k] & free;
      free   = free | ~v_q[k];
    end
    in_ready = free;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0] slice;

    if (k == 0) begin : g_head
      assign a_src[k] = in1;
      assign b_src[k] = b_in;
      assign s_src[k] = '0;
      assign c_src[k] = c0;
      assign load[k]  = in_valid & in_ready;
    end else begin : g_body
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign s_src[k] = s_q[k-1];
      assign c_src[k] = c_q[k-1];
      assign load[k]  = adv[k-1];
    end

    // Slices above k are still zero in s_src, so OR-ing in the new slice is exact.
    assign {c_nx[k], slice} = {1'b0, a_src[k][k*SW +: SW]} + {1'b0, b_src[k][k*SW +: SW]}
                            + (SW+1)'(c_src[k]);
    assign s_nx[k] = s_src[k] | (WIDTH'(slice) << (k*SW));
  end

  assign ovf_nx = (a_src[LAST][MSB] == b_src[LAST][MSB]) && (s_nx[LAST][MSB] != a_src[LAST][MSB]);

`ifdef ADDER_SAT_EN
  assign sum_nx = !ovf_nx          ? s_nx[LAST] :
                  a_src[LAST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum_nx = s_nx[LAST];
`endif

  // Pipeline registers; a stage holds its contents unless it is refilled or drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (load[k]) begin
          v_q[k] <= 1'b1;
          a_q[k] <= a_src[k];
          b_q[k] <= b_src[k];
          s_q[k] <= (k == int'(LAST)) ? sum_nx : s_nx[k];
          c_q[k] <= c_nx[k];
        end else if (adv[k]) begin
          v_q[k] <= 1'b0;
        end
      end
      if (load[LAST]) ovf_q <= ovf_nx;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed corner cases, back-pressure stream, mid-flight reset and a parameter sweep.
module tb_pipelined_adder;

  localparam int NSW = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] in1, in2, sum;

  logic             sw_valid, sw_cin, sw_sub;
  logic [31:0]      sw_in1, sw_in2;
  logic [NSW-1:0]   sw_in_ready, sw_out_valid, sw_cout, sw_ovf;
  logic [31:0]      sw_sum [NSW];
  logic [7:0]       sum8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    pipelined_adder #(.WIDTH(32), .STAGES(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 8 : 32)) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[g]), .in1(sw_in1),
      .in2(sw_in2), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_out_valid[g]), .out_ready(1'b1),
      .sum(sw_sum[g]), .cout(sw_cout[g]), .ovf(sw_ovf[g])
    );
  end

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_sw8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[4]), .in1(sw_in1[7:0]),
    .in2(sw_in2[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_out_valid[4]), .out_ready(1'b1),
    .sum(sum8), .cout(sw_cout[4]), .ovf(sw_ovf[4])
  );
  assign sw_sum[4] = {24'd0, sum8};

  function automatic int sw_stages(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 8;
      3: return 32;
      default: return 2;
    endcase
  endfunction

  // Reference: unsigned add/subtract with borrow semantics, signed range check for overflow.
  function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                input bit c, input bit s, output longint unsigned r,
                                output bit co, output bit ov);
    longint unsigned m, u;
    longint sa, sb, sr, mx, mn;
    m  = (64'd1 << w) - 64'd1;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    sa = (((a >> (w - 1)) & 64'd1) != 0) ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = (((b >> (w - 1)) & 64'd1) != 0) ? longint'(b) - (longint'(1) << w) : longint'(b);
    if (!s) begin
      u  = a + b + 64'(c);
      co = ((u >> w) & 64'd1) != 0;
      sr = sa + sb + longint'(c);
    end else begin
      co = a >= b + 64'(c);
      u  = a - b - 64'(c);
      sr = sa - sb - longint'(c);
    end
    r  = u & m;
    ov = (sr > mx) || (sr < mn);
`ifdef ADDER_SAT_EN
    if (ov) r = (sr > 0) ? 64'(mx) : (64'(mn) & m);
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated beat through the main DUT with latency and result checks.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input bit c,
                       input bit s, input logic [31:0] es, input bit ec, input bit eo);
    int lat;
    @(negedge clk);
    in1 = a; in2 = b; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 3);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
    check({tag, " ovf"}, ovf, eo);
  endtask

  initial begin
    longint unsigned  r;
    bit               co, ov;
    logic [31:0]      a, b;
    bit               c, s;
    logic [31:0]      expq[$];
    logic [31:0]      hold_sum;
    bit               hold_pending;
    int               held, sent, got, cyc, full_seen, lat;
    bit               acc, dlv;
    longint unsigned  er [NSW];
    bit               ec [NSW];
    bit               eo [NSW];
    logic [NSW-1:0]   seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;
    sw_valid = 1'b0; sw_in1 = '0; sw_in2 = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset ovf", ovf, 0);
    check("reset in_ready", in_ready, 1);

    do_op("carry ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
`ifdef ADDER_SAT_EN
    do_op("pos ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    do_op("neg ovf sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
    do_op("pos ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op("neg ovf sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
    do_op("sub borrow", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("sub borrow-in", 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      model(32, 64'(a), 64'(b), c, s, r, co, ov);
      do_op($sformatf("rand%0d", n), a, b, c, s, 32'(r), co, ov);
    end

    // Back-pressure stream: consumer ready pattern 1,0,0,1 repeating.
    held = 0; sent = 0; got = 0; cyc = 0; full_seen = 0; hold_pending = 1'b0; hold_sum = '0;
    while (got < 16 && cyc < 300) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = sent < 16;
      in1 = 32'(sent); in2 = 32'(sent); cin = 1'b0; sub = 1'b0;
      #1;
      if (hold_pending) begin
        check("stream hold valid", out_valid, 1);
        check("stream hold sum", sum, hold_sum);
      end
      check("stream in_ready", in_ready, !(held == 4 && !out_ready));
      if (held == 4) full_seen++;
      dlv = out_valid && out_ready;
      if (dlv) begin
        if (expq.size() == 0) check("stream extra beat", 1, 0);
        else check("stream sum", sum, expq.pop_front());
        got++;
      end
      hold_pending = out_valid && !out_ready;
      hold_sum     = sum;
      acc = in_valid && in_ready;
      if (acc) begin
        expq.push_back(32'(2 * sent));
        sent++;
      end
      held = held + int'(acc) - int'(dlv);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream delivered", got, 16);
    check("stream pipe filled", full_seen > 0, 1);

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in1 = 32'(100 + i); in2 = 32'd1; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst sum", sum, 0);
    check("midrst cout", cout, 0);
    check("midrst in_ready", in_ready, 1);
    out_ready = 1'b1;
    do_op("post reset", 32'd40, 32'd2, 1'b0, 1'b0, 32'd42, 1'b0, 1'b0);

    // Parameter sweep across STAGES and WIDTH.
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 0) begin
        sw_in1 = 32'hFFFF_FFFF; sw_in2 = 32'h0; sw_cin = 1'b1; sw_sub = 1'b0;
      end else begin
        sw_in1 = $urandom; sw_in2 = $urandom;
        sw_cin = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
      end
      sw_valid = 1'b1;
      for (int i = 0; i < NSW; i++) begin
        if (i == 4) model(8, 64'(sw_in1[7:0]), 64'(sw_in2[7:0]), sw_cin, sw_sub, er[i], ec[i], eo[i]);
        else        model(32, 64'(sw_in1), 64'(sw_in2), sw_cin, sw_sub, er[i], ec[i], eo[i]);
      end
      #1;
      check($sformatf("sweep%0d in_ready", n), sw_in_ready, {NSW{1'b1}});
      @(negedge clk);
      sw_valid = 1'b0;
      seen = '0; lat = 0;
      while (seen != {NSW{1'b1}} && lat <= 40) begin
        for (int i = 0; i < NSW; i++) begin
          if (!seen[i] && sw_out_valid[i]) begin
            seen[i] = 1'b1;
            check($sformatf("sweep%0d.%0d sum", n, i), sw_sum[i], er[i]);
            check($sformatf("sweep%0d.%0d cout", n, i), sw_cout[i], ec[i]);
            check($sformatf("sweep%0d.%0d ovf", n, i), sw_ovf[i], eo[i]);
            check($sformatf("sweep%0d.%0d latency", n, i), lat, sw_stages(i) - 1);
          end
        end
        if (seen != {NSW{1'b1}}) begin
          @(negedge clk);
          lat++;
        end
      end
      for (int i = 0; i < NSW; i++)
        if (!seen[i]) check($sformatf("sweep%0d.%0d timeout", n, i), 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
